// File: rtl/axil_master_bridge.sv
// Single-beat register requests -> AXI4-Lite master transactions, one outstanding at a time.
// Latency: AW/W (or AR) valid the cycle after the request; completion pulse 3 cycles after request with a zero-wait slave.
// Backpressure: valids held until handshake; requests only accepted while busy=0 (write+read together queue the read).
module axil_master_bridge #(
    parameter int          ADDR_WIDTH = 32,
    parameter logic [2:0]  AXPROT     = 3'b000
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  reg_wen,
    input  logic [ADDR_WIDTH-1:0] reg_waddr,
    input  logic [31:0]           reg_wdata,
    input  logic [7:0]            reg_wstrb,
    output logic                  reg_wrdy,
    output logic                  reg_werr,
    input  logic                  reg_ren,
    input  logic [ADDR_WIDTH-1:0] reg_raddr,
    output logic [31:0]           reg_rdata,
    output logic                  reg_rrdy,
    output logic                  reg_rerr,
    output logic                  busy,
    output logic [ADDR_WIDTH-1:0] m_axil_awaddr,
    output logic [2:0]            m_axil_awprot,
    output logic                  m_axil_awvalid,
    input  logic                  m_axil_awready,
    output logic [31:0]           m_axil_wdata,
    output logic [3:0]            m_axil_wstrb,
    output logic                  m_axil_wvalid,
    input  logic                  m_axil_wready,
    input  logic [1:0]            m_axil_bresp,
    input  logic                  m_axil_bvalid,
    output logic                  m_axil_bready,
    output logic [ADDR_WIDTH-1:0] m_axil_araddr,
    output logic [2:0]            m_axil_arprot,
    output logic                  m_axil_arvalid,
    input  logic                  m_axil_arready,
    input  logic [31:0]           m_axil_rdata,
    input  logic [1:0]            m_axil_rresp,
    input  logic                  m_axil_rvalid,
    output logic                  m_axil_rready
);

    typedef enum logic [2:0] {IDLE, WR_REQ, WR_RESP, RD_REQ, RD_RESP} state_t;

    state_t state, state_nxt;
    logic   aw_pend, w_pend, rd_pend;
    logic   aw_hs, w_hs, b_hs, ar_hs, r_hs;
    logic   unused_wstrb_hi;

    // Upper strobe bits have no lane on a 32-bit AXI-Lite data bus.
    assign unused_wstrb_hi = ^reg_wstrb[7:4];

    assign aw_hs = m_axil_awvalid & m_axil_awready;
    assign w_hs  = m_axil_wvalid  & m_axil_wready;
    assign b_hs  = m_axil_bvalid  & m_axil_bready;
    assign ar_hs = m_axil_arvalid & m_axil_arready;
    assign r_hs  = m_axil_rvalid  & m_axil_rready;

    // The write channels are driven straight from their pending flops, so they are registered.
    assign m_axil_awvalid = aw_pend;
    assign m_axil_wvalid  = w_pend;
    assign m_axil_awprot  = AXPROT;
    assign m_axil_arprot  = AXPROT;
    assign busy           = (state != IDLE) | rd_pend;

    // State register.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) state <= IDLE;
        else         state <= state_nxt;
    end

    // Next-state logic; a queued read follows the write response without passing through IDLE.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (reg_wen)                   state_nxt = WR_REQ;
                     else if (reg_ren)              state_nxt = RD_REQ;
            WR_REQ:  if ((!aw_pend || aw_hs) && (!w_pend || w_hs))
                                                    state_nxt = WR_RESP;
            WR_RESP: if (b_hs)                      state_nxt = rd_pend ? RD_REQ : IDLE;
            RD_REQ:  if (ar_hs)                     state_nxt = RD_RESP;
            RD_RESP: if (r_hs)                      state_nxt = IDLE;
            default:                                state_nxt = IDLE;
        endcase
    end

    // Request capture, channel valid/ready registers and completion reporting.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            aw_pend        <= 1'b0;
            w_pend         <= 1'b0;
            rd_pend        <= 1'b0;
            m_axil_awaddr  <= '0;
            m_axil_wdata   <= '0;
            m_axil_wstrb   <= '0;
            m_axil_araddr  <= '0;
            m_axil_arvalid <= 1'b0;
            m_axil_bready  <= 1'b0;
            m_axil_rready  <= 1'b0;
            reg_wrdy       <= 1'b0;
            reg_werr       <= 1'b0;
            reg_rrdy       <= 1'b0;
            reg_rerr       <= 1'b0;
            reg_rdata      <= '0;
        end else begin
            if (state == IDLE && reg_wen) begin
                m_axil_awaddr <= reg_waddr;
                m_axil_wdata  <= reg_wdata;
                m_axil_wstrb  <= reg_wstrb[3:0];
                aw_pend       <= 1'b1;
                w_pend        <= 1'b1;
                rd_pend       <= reg_ren;
            end else begin
                if (aw_hs) aw_pend <= 1'b0;
                if (w_hs)  w_pend  <= 1'b0;
                if (b_hs)  rd_pend <= 1'b0;
            end
            // Address is captured here even for a queued read; arvalid stays low until RD_REQ.
            if (state == IDLE && reg_ren)
                m_axil_araddr <= reg_raddr;
            m_axil_arvalid <= (state_nxt == RD_REQ);
            m_axil_bready  <= (state_nxt == WR_RESP);
            m_axil_rready  <= (state_nxt == RD_RESP);
            reg_wrdy       <= b_hs;
            reg_rrdy       <= r_hs;
            if (b_hs) reg_werr <= (m_axil_bresp != 2'b00);
            if (r_hs) begin
                reg_rdata <= m_axil_rdata;
                reg_rerr  <= (m_axil_rresp != 2'b00);
            end
        end
    end

endmodule

// File: doc/axil_master_bridge.md
# axil_master_bridge

Converts the codebase's single-beat register request interface (wen/waddr/wdata/wstrb/wrdy, ren/raddr/rdata/rrdy) into AXI4-Lite master transactions. It is the initiator-side counterpart of the PRC's AXI-Lite slave bridge. It lets an on-chip sequencer (e.g. a PR test driver or a boot loader) program the PRC register map over a standard AXI-Lite link. The bridge runs one outstanding transaction at a time and returns the AXI response code to the requester.

## Interface
- ADDR_WIDTH, 32, AXI-Lite address width; reg addresses are passed through unchanged
- AXPROT, 3'b000, constant value driven on m_axil_awprot / m_axil_arprot
- clk  input  1  sole clock
- resetn  input  1  asynchronous, active-low reset
- reg_wen  input  1  write request; sampled only when busy=0
- reg_waddr  input  ADDR_WIDTH  write address
- reg_wdata  input  32  write data
- reg_wstrb  input  8  byte strobes; bits [3:0] used, [7:4] ignored
- reg_wrdy  output  1  one-cycle pulse: write completed
- reg_werr  output  1  valid with reg_wrdy; 1 when BRESP != OKAY
- reg_ren  input  1  read request; sampled when busy=0 or latched as pending (see Operation)
- reg_raddr  input  ADDR_WIDTH  read address
- reg_rdata  output  32  read data; valid with reg_rrdy and held until next read completes
- reg_rrdy  output  1  one-cycle pulse: read completed
- reg_rerr  output  1  valid with reg_rrdy; 1 when RRESP != OKAY
- busy  output  1  1 whenever state != IDLE or a read is pending
- m_axil_awaddr / awprot / awvalid  output  ADDR_WIDTH / 3 / 1  write address channel
- m_axil_awready  input  1
- m_axil_wdata / wstrb / wvalid  output  32 / 4 / 1  write data channel
- m_axil_wready  input  1
- m_axil_bresp / bvalid  input  2 / 1  write response
- m_axil_bready  output  1
- m_axil_araddr / arprot / arvalid  output  ADDR_WIDTH / 3 / 1  read address channel
- m_axil_arready  input  1
- m_axil_rdata / rresp / rvalid  input  32 / 2 / 1  read data channel
- m_axil_rready  output  1

## Operation
- States: IDLE, WR_REQ, WR_RESP, RD_REQ, RD_RESP.
- IDLE with reg_wen=1: latch waddr, wdata, wstrb[3:0]; set aw_pend=w_pend=1; go to WR_REQ.
- IDLE with reg_ren=1 and reg_wen=0: latch raddr; go to RD_REQ.
- IDLE with both asserted in the same cycle: the write wins. The read address is latched into a pending slot (rd_pend=1) and issued right after the write completes. This adds no IDLE cycle: WR_RESP goes straight to RD_REQ.
- reg_ren asserted while busy and rd_pend=0 is ignored. Requesters must wait for busy=0.
- WR_REQ:
  - awvalid=aw_pend and wvalid=w_pend.
  - aw_pend clears on awvalid&awready, and w_pend clears on wvalid&wready. The two channels complete independently, in either order or in the same cycle.
  - When both are clear, go to WR_RESP.
- WR_RESP: bready=1. On bvalid, werr<=(bresp!=0) and wrdy pulses. Next state is RD_REQ if rd_pend (rd_pend then clears), else IDLE.
- RD_REQ: arvalid=1. On arready, go to RD_RESP.
- RD_RESP: rready=1. On rvalid, rdata<=m_axil_rdata, rerr<=(rresp!=0), rrdy pulses. Go to IDLE.
- All AXI outputs are registered. Valid never drops before its handshake, and address/data stay stable while valid is high.
- Reset (asynchronous, any state): state=IDLE, aw_pend=w_pend=rd_pend=0. All valid/ready outputs, reg_wrdy, reg_rrdy, reg_werr, reg_rerr and busy go to 0; reg_rdata, address and data outputs go to 0. An in-flight transaction is abandoned with no completion pulse.

## Timing
- Request sampled at edge N: awvalid/wvalid (or arvalid) high after edge N; busy high after edge N.
- Zero-wait slave: write = AW/W handshake at edge N+1, bvalid handshake at edge N+2, wrdy high in cycle after N+2. That gives a 3-cycle request-to-wrdy latency.
- Read uses the same timing: rrdy high in cycle after N+2.
- bready/rready are high only in WR_RESP/RD_RESP. They are not pre-asserted.
- wrdy/rrdy are exactly one cycle wide. busy drops in the same cycle as the last completion pulse.
- Back-to-back: a new request may be sampled in the first cycle busy=0. Minimum spacing is 3 cycles per transaction.

## Test plan
- Zero-wait write: waddr=0x0000_0010, wdata=0xA5A5_1234, wstrb=8'hF3 -> AW/W carry those values with wstrb=4'h3. wrdy pulses 3 cycles after request with werr=0.
- Skewed channels: awready delayed 4 cycles, wready immediate -> wvalid drops after 1 cycle, awvalid is held 5 cycles stable, and exactly one wrdy pulse follows bvalid.
- Read with slave error: raddr=0x800, rvalid after 2 wait cycles, rresp=2'b10, rdata=0xDEAD_0001 -> rrdy pulse with rerr=1 and reg_rdata=0xDEAD_0001, held afterwards.
- Simultaneous wen and ren in IDLE: write 0x4 and read 0x8 -> the write completes first. arvalid asserts in the cycle after the bvalid handshake, then rrdy follows; busy stays high throughout.
- Ignored request: reg_ren pulsed while in WR_RESP with rd_pend=0 -> no AR transaction is issued.
- Reset mid-read: resetn low while arvalid=1 -> all outputs go to 0 immediately, and no rrdy appears after reset release.
